// File: rtl/ram_port_arbiter_if.sv
// Requester-side command/response bundle for ram_port_arbiter.
// The master is the client block; the slave is the arbiter.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one write/read RAM port pair between requesters A and B.
// Read results are routed back to the issuer through a latency-matched ID pipeline.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave a_if,
  ram_port_arbiter_if.slave b_if,
  output logic              wr_enable_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] data_in_o,
  output logic              rd_enable_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] data_out_i
);

  localparam int unsigned PIPE_D  = RD_LAT + 1;
  localparam logic [0:0]  GRANT_A = 1'b0;
  localparam logic [0:0]  GRANT_B = 1'b1;

  logic [0:0]        last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [PIPE_D-1:0] pipe_vld_q, pipe_vld_d;
  logic [PIPE_D-1:0] pipe_id_q, pipe_id_d;
  logic              rvalid_a_q, rvalid_a_d;
  logic              rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic              gnt_a_c, gnt_b_c, gnt_any_c, sel_we_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  // Arbitration: a conflict goes to whichever requester was not granted last.
  always_comb begin
    gnt_a_c = 1'b0;
    gnt_b_c = 1'b0;
    if (!rst) begin
      if (a_if.req && (!b_if.req || last_grant_q == GRANT_B)) gnt_a_c = 1'b1;
      else if (b_if.req)                                        gnt_b_c = 1'b1;
    end
  end

  assign gnt_any_c   = gnt_a_c | gnt_b_c;
  assign sel_we_c    = gnt_a_c ? a_if.we    : b_if.we;
  assign sel_addr_c  = gnt_a_c ? a_if.addr  : b_if.addr;
  assign sel_wdata_c = gnt_a_c ? a_if.wdata : b_if.wdata;

  always_comb begin
    last_grant_d = last_grant_q;
    wr_en_d      = gnt_any_c & sel_we_c;
    rd_en_d      = gnt_any_c & ~sel_we_c;
    wr_addr_d    = wr_addr_q;
    data_in_d    = data_in_q;
    rd_addr_d    = rd_addr_q;
    if (gnt_a_c)      last_grant_d = GRANT_A;
    else if (gnt_b_c) last_grant_d = GRANT_B;
    if (wr_en_d) begin
      wr_addr_d = sel_addr_c;
      data_in_d = sel_wdata_c;
    end
    if (rd_en_d) rd_addr_d = sel_addr_c;
    // Last stage lines up with the cycle in which data_out is valid.
    pipe_vld_d = {pipe_vld_q[PIPE_D-2:0], rd_en_d};
    pipe_id_d  = {pipe_id_q[PIPE_D-2:0], gnt_b_c};
    rvalid_a_d = pipe_vld_q[PIPE_D-1] & ~pipe_id_q[PIPE_D-1];
    rvalid_b_d = pipe_vld_q[PIPE_D-1] &  pipe_id_q[PIPE_D-1];
    rdata_a_d  = rvalid_a_d ? data_out_i : rdata_a_q;
    rdata_b_d  = rvalid_b_d ? data_out_i : rdata_b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_B;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      data_in_q    <= '0;
      pipe_vld_q   <= '0;
      pipe_id_q    <= '0;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      data_in_q    <= data_in_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_id_q    <= pipe_id_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
    end
  end

  assign a_if.gnt    = gnt_a_c;
  assign b_if.gnt    = gnt_b_c;
  assign a_if.rvalid = rvalid_a_q;
  assign b_if.rvalid = rvalid_b_q;
  assign a_if.rdata  = rdata_a_q;
  assign b_if.rdata  = rdata_b_q;
  assign wr_enable_o = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign data_in_o   = data_in_q;
  assign rd_enable_o = rd_en_q;
  assign rd_addr_o   = rd_addr_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance with RD_LAT=1 and one with RD_LAT=3,
// each backed by a small behavioural RAM.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(4), .DATA_W(32)) a1 ();
  ram_port_arbiter_if #(.ADDR_W(4), .DATA_W(32)) b1 ();
  ram_port_arbiter_if #(.ADDR_W(4), .DATA_W(32)) a3 ();
  ram_port_arbiter_if #(.ADDR_W(4), .DATA_W(32)) b3 ();

  logic        wr_en1, rd_en1, wr_en3, rd_en3;
  logic [3:0]  wr_addr1, rd_addr1, wr_addr3, rd_addr3;
  logic [31:0] din1, dout1, din3, dout3;

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(32), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .a_if(a1), .b_if(b1),
    .wr_enable_o(wr_en1), .wr_addr_o(wr_addr1), .data_in_o(din1),
    .rd_enable_o(rd_en1), .rd_addr_o(rd_addr1), .data_out_i(dout1)
  );

  ram_port_arbiter #(.ADDR_W(4), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .a_if(a3), .b_if(b3),
    .wr_enable_o(wr_en3), .wr_addr_o(wr_addr3), .data_in_o(din3),
    .rd_enable_o(rd_en3), .rd_addr_o(rd_addr3), .data_out_i(dout3)
  );

  // RAM models: data_out valid RD_LAT cycles after rd_enable is sampled high
  logic [31:0] mem1 [16];
  logic [31:0] mem3 [16];
  logic [31:0] s0_3, s1_3;

  always @(posedge clk) begin
    if (wr_en1) mem1[wr_addr1] <= din1;
    if (rd_en1) dout1 <= mem1[rd_addr1];
    if (wr_en3) mem3[wr_addr3] <= din3;
    s0_3  <= mem3[rd_addr3];
    s1_3  <= s0_3;
    dout3 <= s1_3;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic r, input logic w, input logic [3:0] ad, input logic [31:0] d);
    a1.req = r; a1.we = w; a1.addr = ad; a1.wdata = d;
  endtask

  task automatic drv_b(input logic r, input logic w, input logic [3:0] ad, input logic [31:0] d);
    b1.req = r; b1.we = w; b1.addr = ad; b1.wdata = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv_a(1'b1, 1'b1, 4'h1, 32'h1);
    drv_b(1'b1, 1'b0, 4'h2, 32'h2);
    cyc(); #1;
    total_cnt++; if (a1.gnt !== 1'b0) $display("FAIL reset_gnt_a: got %b expected 0", a1.gnt); else pass_cnt++;
    total_cnt++; if (b1.gnt !== 1'b0) $display("FAIL reset_gnt_b: got %b expected 0", b1.gnt); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (wr_en1 !== 1'b0 || rd_en1 !== 1'b0) $display("FAIL reset_strobes: got wr=%b rd=%b expected 0 0", wr_en1, rd_en1); else pass_cnt++;
    total_cnt++; if (a1.rvalid !== 1'b0 || b1.rvalid !== 1'b0) $display("FAIL reset_rvalid: got a=%b b=%b expected 0 0", a1.rvalid, b1.rvalid); else pass_cnt++;
    total_cnt++; if (a1.rdata !== 32'h0 || din1 !== 32'h0 || wr_addr1 !== 4'h0) $display("FAIL reset_regs: got rdata=%h din=%h waddr=%h expected 0", a1.rdata, din1, wr_addr1); else pass_cnt++;
    drv_a(1'b0, 1'b0, 4'h0, 32'h0);
    drv_b(1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic test_single_rw();
    cyc(); rst = 1'b0; drv_a(1'b1, 1'b1, 4'h3, 32'hDEADBEEF); #1;
    total_cnt++; if (a1.gnt !== 1'b1 || b1.gnt !== 1'b0) $display("FAIL single_wr_gnt: got a=%b b=%b expected 1 0", a1.gnt, b1.gnt); else pass_cnt++;
    cyc(); drv_a(1'b1, 1'b0, 4'h3, 32'h0); #1;
    total_cnt++; if (wr_en1 !== 1'b1 || rd_en1 !== 1'b0) $display("FAIL single_wr_strobe: got wr=%b rd=%b expected 1 0", wr_en1, rd_en1); else pass_cnt++;
    total_cnt++; if (wr_addr1 !== 4'h3 || din1 !== 32'hDEADBEEF) $display("FAIL single_wr_fields: got addr=%h data=%h expected 3 deadbeef", wr_addr1, din1); else pass_cnt++;
    total_cnt++; if (a1.gnt !== 1'b1) $display("FAIL single_rd_gnt: got %b expected 1", a1.gnt); else pass_cnt++;
    cyc(); drv_a(1'b0, 1'b0, 4'h0, 32'h0); #1;
    total_cnt++; if (rd_en1 !== 1'b1 || wr_en1 !== 1'b0 || rd_addr1 !== 4'h3) $display("FAIL single_rd_issue: got rd=%b wr=%b addr=%h expected 1 0 3", rd_en1, wr_en1, rd_addr1); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (a1.rvalid !== 1'b0 || rd_en1 !== 1'b0) $display("FAIL single_rvalid_early: got rvalid=%b rd=%b expected 0 0", a1.rvalid, rd_en1); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (a1.rvalid !== 1'b1 || a1.rdata !== 32'hDEADBEEF) $display("FAIL single_rdata: got rvalid=%b data=%h expected 1 deadbeef", a1.rvalid, a1.rdata); else pass_cnt++;
    total_cnt++; if (b1.rvalid !== 1'b0) $display("FAIL single_rvalid_b: got %b expected 0", b1.rvalid); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (a1.rvalid !== 1'b0 || a1.rdata !== 32'hDEADBEEF) $display("FAIL single_rdata_hold: got rvalid=%b data=%h expected 0 deadbeef", a1.rvalid, a1.rdata); else pass_cnt++;
  endtask

  task automatic test_alternation();
    rst = 1'b1;
    cyc(); cyc();
    cyc(); rst = 1'b0;
    drv_a(1'b1, 1'b1, 4'h1, 32'hAAAA0001);
    drv_b(1'b1, 1'b1, 4'h2, 32'hBBBB0002);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      #1;
      total_cnt++;
      if (a1.gnt !== ((i % 2) == 0) || b1.gnt !== ((i % 2) == 1))
        $display("FAIL alt_gnt_%0d: got a=%b b=%b expected %b %b", i, a1.gnt, b1.gnt, (i % 2) == 0, (i % 2) == 1);
      else pass_cnt++;
      if (i != 0) begin
        total_cnt++;
        if (wr_en1 !== 1'b1 || din1 !== (((i - 1) % 2) == 0 ? 32'hAAAA0001 : 32'hBBBB0002))
          $display("FAIL alt_issue_%0d: got wr=%b data=%h expected 1 %h", i, wr_en1, din1, (((i - 1) % 2) == 0 ? 32'hAAAA0001 : 32'hBBBB0002));
        else pass_cnt++;
      end
    end
    cyc(); drv_a(1'b0, 1'b0, 4'h0, 32'h0); drv_b(1'b0, 1'b0, 4'h0, 32'h0); #1;
    total_cnt++; if (wr_en1 !== 1'b1 || wr_addr1 !== 4'h2) $display("FAIL alt_last_issue: got wr=%b addr=%h expected 1 2", wr_en1, wr_addr1); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (wr_en1 !== 1'b0 || rd_en1 !== 1'b0) $display("FAIL alt_idle: got wr=%b rd=%b expected 0 0", wr_en1, rd_en1); else pass_cnt++;
  endtask

  task automatic test_interleaved_reads();
    cyc(); drv_b(1'b1, 1'b1, 4'h5, 32'h11111111); #1;
    total_cnt++; if (b1.gnt !== 1'b1 || a1.gnt !== 1'b0) $display("FAIL intl_b_wr_gnt: got a=%b b=%b expected 0 1", a1.gnt, b1.gnt); else pass_cnt++;
    cyc(); drv_b(1'b0, 1'b0, 4'h0, 32'h0); drv_a(1'b1, 1'b1, 4'h6, 32'h22222222); #1;
    total_cnt++; if (a1.gnt !== 1'b1) $display("FAIL intl_a_wr_gnt: got %b expected 1", a1.gnt); else pass_cnt++;
    cyc(); drv_a(1'b1, 1'b0, 4'h5, 32'h0); drv_b(1'b1, 1'b0, 4'h6, 32'h0); #1;
    total_cnt++; if (b1.gnt !== 1'b1 || a1.gnt !== 1'b0) $display("FAIL intl_conflict1: got a=%b b=%b expected 0 1", a1.gnt, b1.gnt); else pass_cnt++;
    cyc(); drv_b(1'b0, 1'b0, 4'h0, 32'h0); #1;
    total_cnt++; if (a1.gnt !== 1'b1 || rd_addr1 !== 4'h6 || rd_en1 !== 1'b1) $display("FAIL intl_conflict2: got gnt_a=%b rd=%b raddr=%h expected 1 1 6", a1.gnt, rd_en1, rd_addr1); else pass_cnt++;
    cyc(); drv_a(1'b0, 1'b0, 4'h0, 32'h0); #1;
    total_cnt++; if (rd_en1 !== 1'b1 || rd_addr1 !== 4'h5) $display("FAIL intl_rd_a_issue: got rd=%b addr=%h expected 1 5", rd_en1, rd_addr1); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (b1.rvalid !== 1'b1 || b1.rdata !== 32'h22222222 || a1.rvalid !== 1'b0) $display("FAIL intl_ret_b: got vb=%b db=%h va=%b expected 1 22222222 0", b1.rvalid, b1.rdata, a1.rvalid); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (a1.rvalid !== 1'b1 || a1.rdata !== 32'h11111111 || b1.rvalid !== 1'b0) $display("FAIL intl_ret_a: got va=%b da=%h vb=%b expected 1 11111111 0", a1.rvalid, a1.rdata, b1.rvalid); else pass_cnt++;
  endtask

  task automatic test_withdrawn();
    cyc(); drv_b(1'b1, 1'b1, 4'h8, 32'h00000088); #1;
    total_cnt++; if (b1.gnt !== 1'b1) $display("FAIL wd_pre_gnt_b: got %b expected 1", b1.gnt); else pass_cnt++;
    cyc(); drv_a(1'b1, 1'b1, 4'h7, 32'h00000077); drv_b(1'b1, 1'b0, 4'h9, 32'h0); #1;
    total_cnt++; if (a1.gnt !== 1'b1 || b1.gnt !== 1'b0) $display("FAIL wd_conflict: got a=%b b=%b expected 1 0", a1.gnt, b1.gnt); else pass_cnt++;
    cyc(); drv_a(1'b0, 1'b0, 4'h0, 32'h0); drv_b(1'b0, 1'b0, 4'h0, 32'h0); #1;
    total_cnt++; if (b1.gnt !== 1'b0 || wr_en1 !== 1'b1 || wr_addr1 !== 4'h7 || rd_en1 !== 1'b0) $display("FAIL wd_a_issue: got gnt_b=%b wr=%b addr=%h rd=%b expected 0 1 7 0", b1.gnt, wr_en1, wr_addr1, rd_en1); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      total_cnt++;
      if (wr_en1 !== 1'b0 || rd_en1 !== 1'b0 || b1.rvalid !== 1'b0)
        $display("FAIL wd_no_b_%0d: got wr=%b rd=%b rvalid_b=%b expected 0 0 0", i, wr_en1, rd_en1, b1.rvalid);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_read();
    cyc(); drv_a(1'b1, 1'b0, 4'h2, 32'h0); #1;
    total_cnt++; if (a1.gnt !== 1'b1) $display("FAIL rmr_rd_gnt: got %b expected 1", a1.gnt); else pass_cnt++;
    cyc(); drv_a(1'b1, 1'b1, 4'h4, 32'h44444444); #1;
    total_cnt++; if (rd_en1 !== 1'b1 || a1.gnt !== 1'b1) $display("FAIL rmr_rd_issue: got rd=%b gnt=%b expected 1 1", rd_en1, a1.gnt); else pass_cnt++;
    cyc(); rst = 1'b1; drv_b(1'b1, 1'b1, 4'h5, 32'h55555555); #1;
    total_cnt++; if (a1.gnt !== 1'b0 || b1.gnt !== 1'b0) $display("FAIL rmr_gnt_in_rst: got a=%b b=%b expected 0 0", a1.gnt, b1.gnt); else pass_cnt++;
    total_cnt++; if (wr_en1 !== 1'b1) $display("FAIL rmr_wr_before_edge: got %b expected 1", wr_en1); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (a1.rvalid !== 1'b0) $display("FAIL rmr_rvalid_dropped: got %b expected 0", a1.rvalid); else pass_cnt++;
    total_cnt++; if (wr_en1 !== 1'b0 || rd_en1 !== 1'b0) $display("FAIL rmr_strobes: got wr=%b rd=%b expected 0 0", wr_en1, rd_en1); else pass_cnt++;
    cyc(); rst = 1'b0; #1;
    total_cnt++; if (a1.gnt !== 1'b1 || b1.gnt !== 1'b0) $display("FAIL rmr_post_conflict: got a=%b b=%b expected 1 0", a1.gnt, b1.gnt); else pass_cnt++;
    total_cnt++; if (a1.rvalid !== 1'b0) $display("FAIL rmr_rvalid_post: got %b expected 0", a1.rvalid); else pass_cnt++;
    cyc(); drv_a(1'b0, 1'b0, 4'h0, 32'h0); #1;
    total_cnt++; if (b1.gnt !== 1'b1 || wr_addr1 !== 4'h4) $display("FAIL rmr_post_b: got gnt_b=%b waddr=%h expected 1 4", b1.gnt, wr_addr1); else pass_cnt++;
    cyc(); drv_b(1'b0, 1'b0, 4'h0, 32'h0); #1;
    total_cnt++; if (a1.rvalid !== 1'b0 || din1 !== 32'h55555555) $display("FAIL rmr_tail: got rvalid=%b din=%h expected 0 55555555", a1.rvalid, din1); else pass_cnt++;
  endtask

  task automatic test_rd_lat3();
    cyc(); a3.req = 1'b1; a3.we = 1'b1; a3.addr = 4'h3; a3.wdata = 32'hDEADBEEF; #1;
    total_cnt++; if (a3.gnt !== 1'b1) $display("FAIL lat3_wr_gnt: got %b expected 1", a3.gnt); else pass_cnt++;
    cyc(); a3.we = 1'b0; #1;
    total_cnt++; if (wr_en3 !== 1'b1 || din3 !== 32'hDEADBEEF || a3.gnt !== 1'b1) $display("FAIL lat3_wr_issue: got wr=%b data=%h gnt=%b expected 1 deadbeef 1", wr_en3, din3, a3.gnt); else pass_cnt++;
    cyc(); a3.req = 1'b0; #1;
    total_cnt++; if (rd_en3 !== 1'b1 || rd_addr3 !== 4'h3) $display("FAIL lat3_rd_issue: got rd=%b addr=%h expected 1 3", rd_en3, rd_addr3); else pass_cnt++;
    for (int i = 3; i < 6; i++) begin
      cyc(); #1;
      total_cnt++;
      if (a3.rvalid !== 1'b0) $display("FAIL lat3_early_%0d: got %b expected 0", i, a3.rvalid);
      else pass_cnt++;
    end
    cyc(); #1;
    total_cnt++; if (a3.rvalid !== 1'b1 || a3.rdata !== 32'hDEADBEEF || a3.rvalid === b3.rvalid) $display("FAIL lat3_rdata: got va=%b vb=%b data=%h expected 1 0 deadbeef", a3.rvalid, b3.rvalid, a3.rdata); else pass_cnt++;
    cyc(); #1;
    total_cnt++; if (a3.rvalid !== 1'b0) $display("FAIL lat3_pulse: got %b expected 0", a3.rvalid); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    drv_a(1'b0, 1'b0, 4'h0, 32'h0);
    drv_b(1'b0, 1'b0, 4'h0, 32'h0);
    a3.req = 1'b0; a3.we = 1'b0; a3.addr = 4'h0; a3.wdata = 32'h0;
    b3.req = 1'b0; b3.we = 1'b0; b3.addr = 4'h0; b3.wdata = 32'h0;
    test_reset();
    test_single_rw();
    test_alternation();
    test_interleaved_reads();
    test_withdrawn();
    test_reset_mid_read();
    test_rd_lat3();
    cyc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares the single-port-pair RAM (separate write and read ports, 16 x 32-bit) between two requesters, A and B.
- Accepts at most one command per cycle and drives registered RAM write/read controls.
- Tracks in-flight reads and returns each read result only to the requester that issued it.
- Sits between the two client blocks and the RAM; it is the only driver of the RAM control pins.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 32, RAM data width
RD_LAT, 1, cycles from rd_enable sampled high to data_out valid (1..4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_a  in  1  requester A command request
we_a  in  1  A: 1 = write, 0 = read
addr_a  in  ADDR_W  A command address
wdata_a  in  DATA_W  A write data
gnt_a  out  1  A command accepted this cycle (combinational)
rvalid_a  out  1  A read data valid (registered)
rdata_a  out  DATA_W  A read data (registered)
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
wr_enable  out  1  RAM write strobe (registered)
wr_addr  out  ADDR_W  RAM write address (registered)
data_in  out  DATA_W  RAM write data (registered)
rd_enable  out  1  RAM read strobe (registered)
rd_addr  out  ADDR_W  RAM read address (registered)
data_out  in  DATA_W  RAM read data

Behaviour:
- Reset: all registered outputs are 0, last_grant = B (A wins the first conflict), read-tracking pipeline is cleared. gnt_a and gnt_b are 0 while rst is high.
- Handshake:
  - A requester raises req_x with we/addr/wdata stable and holds them until it sees gnt_x high at a rising edge.
  - It may change or drop them in the cycle after the grant.
  - Dropping req_x before the grant withdraws the command with no side effect.
- Arbitration, combinational in cycle N:
  - Only one of req_a/req_b high: that requester is granted.
  - Both high: the requester that is not last_grant is granted.
  - Neither high: no grant.
  - Exactly one of gnt_a/gnt_b is high at most.
  - last_grant updates at the edge only when a grant occurs.
- Issue, cycle N+1:
  - Granted write: wr_enable=1, wr_addr/data_in = granted fields, rd_enable=0.
  - Granted read: rd_enable=1, rd_addr = granted address, wr_enable=0.
  - No grant: both strobes 0; address/data hold their previous values.
  - wr_enable and rd_enable are never high in the same cycle.
- Read return:
  - Requester ID and valid bit enter a shift pipeline of depth RD_LAT+1 at issue.
  - data_out is sampled in cycle N+1+RD_LAT.
  - rvalid_x and rdata_x are high/valid in cycle N+2+RD_LAT, for one cycle. With RD_LAT=1 this is a 3-cycle grant-to-data latency.
  - rdata_x holds its last value when rvalid_x is low.
  - Reads return in issue order; back-to-back reads give back-to-back rvalid pulses.
- Throughput: one command per cycle sustained. With both requesters requesting continuously, grants alternate A,B,A,B.
- Ordering: commands reach the RAM in grant order. A read granted after a write to the same address returns the new data.
- Reset mid-operation: in-flight reads are discarded (no rvalid afterwards), strobes drop on the first reset edge, and arbitration restarts with A priority.

Test Plan:
- Reset then single write/read: A writes 0xDEADBEEF to addr 3 (gnt_a in cycle 1, wr_enable in cycle 2), then A reads addr 3. rd_enable is high one cycle after its grant, and rvalid_a=1 with rdata_a=0xDEADBEEF 3 cycles after the grant; rvalid_b stays 0.
- Simultaneous requests from reset: req_a and req_b both high. Expect gnt_a first, then gnt_b, then alternation A,B,A,B over 8 cycles with no lost or duplicate grants.
- Interleaved reads with routing: B writes 0x11111111 to addr 5; A writes 0x22222222 to addr 6; then A reads 5 and B reads 6 back-to-back. Required: rdata_a=0x11111111 and rdata_b=0x22222222, on consecutive rvalid cycles.
- Withdrawn request: req_b high for 1 cycle while A holds the grant, then req_b drops. Expect no gnt_b and no RAM strobe for B.
- Reset mid-read: A read of addr 2 issued, then rst asserted in the cycle before its rvalid. Expect rvalid_a=0 throughout, strobes=0, and the first post-reset conflict granted to A.
- RD_LAT=3 configuration: repeat the single write/read case. Expect rvalid_a 5 cycles after the grant, with correct data.
